// File: rtl/seq_sched_pkg.sv
// Shared types and width helpers for the sequence-detector scheduler.
package seq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Requester ID width: $clog2(NREQ).
  function automatic int unsigned id_w(input int unsigned nreq);
    return $clog2(nreq);
  endfunction

  // Hit counter width: must hold 0..WORD_W.
  function automatic int unsigned cnt_w(input int unsigned word_w);
    return $clog2(word_w + 1);
  endfunction

  // Bit index counter width: counts 0..WORD_W-1.
  function automatic int unsigned bitcnt_w(input int unsigned word_w);
    return $clog2(word_w);
  endfunction

endpackage

// File: rtl/seq_detect_core.sv
// Bit-serial overlapping pattern detector; history never spans a clear.
module seq_detect_core #(
  parameter int unsigned          PAT_W   = 4,
  parameter logic [PAT_W-1:0]     PATTERN = 4'b1010
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic in_valid,
  input  logic in_bit,
  output logic match
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-2:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  window;
  logic              full;

  // Window as it will look once the incoming bit is shifted in.
  assign window = {hist, in_bit};
  assign full   = (fill >= FILL_W'(PAT_W - 1));
  assign match  = in_valid && full && (window == PATTERN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (in_valid) begin
      hist <= window[PAT_W-2:0];
      if (!full) fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler time-sharing one sequence detector between requesters.
// Define SEQ_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins arbitration.
module seq_detect_scheduler
  import seq_sched_pkg::*;
#(
  parameter int unsigned      NREQ    = 4,
  parameter int unsigned      WORD_W  = 8,
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*WORD_W-1:0]      word_in,
  output logic [NREQ-1:0]             grant,
  output logic                        busy,
  output logic                        serial_bit,
  output logic                        serial_valid,
  output logic                        done,
  output logic [id_w(NREQ)-1:0]       done_id,
  output logic [cnt_w(WORD_W)-1:0]    hit_count
);

  localparam int unsigned ID_W     = id_w(NREQ);
  localparam int unsigned CNT_W    = cnt_w(WORD_W);
  localparam int unsigned BITCNT_W = bitcnt_w(WORD_W);

  state_t              state_q, state_d;
  logic                load, shift_en, report;
  logic                any_req, found;
  logic [ID_W-1:0]     winner;
  logic [ID_W-1:0]     cur_id;
  logic [WORD_W-1:0]   sreg;
  logic [BITCNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0]    hits;
  logic                match;
`ifndef SEQ_SCHED_FIXED_PRIO_EN
  logic [ID_W-1:0]     last_id;
`endif

  // Arbiter: picks the winner among active requests.
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    any_req = |req;
`ifdef SEQ_SCHED_FIXED_PRIO_EN
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req[ID_W'(i)]) begin
        winner = ID_W'(i);
        found  = 1'b1;
      end
    end
`else
    for (int unsigned i = 1; i <= NREQ; i++) begin
      int unsigned idx;
      idx = (32'(last_id) + i) % NREQ;
      if (!found && req[ID_W'(idx)]) begin
        winner = ID_W'(idx);
        found  = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and datapath controls.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    report   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (bit_cnt == BITCNT_W'(WORD_W - 1)) state_d = REPORT;
      end
      REPORT: begin
        report  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  seq_detect_core #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .clear    (load),
    .in_valid (shift_en),
    .in_bit   (sreg[WORD_W-1]),
    .match    (match)
  );

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant        <= '0;
      busy         <= 1'b0;
      serial_bit   <= 1'b0;
      serial_valid <= 1'b0;
      done         <= 1'b0;
      done_id      <= '0;
      hit_count    <= '0;
      cur_id       <= '0;
      sreg         <= '0;
      bit_cnt      <= '0;
      hits         <= '0;
`ifndef SEQ_SCHED_FIXED_PRIO_EN
      last_id      <= ID_W'(NREQ - 1);
`endif
    end else begin
      grant <= '0;
      done  <= 1'b0;
      if (load) begin
        grant   <= NREQ'(1) << winner;
        busy    <= 1'b1;
        sreg    <= word_in[32'(winner) * WORD_W +: WORD_W];
        cur_id  <= winner;
        bit_cnt <= '0;
        hits    <= '0;
      end else if (state_q == IDLE) begin
        busy <= 1'b0;
      end
      if (shift_en) begin
        serial_bit   <= sreg[WORD_W-1];
        serial_valid <= 1'b1;
        sreg         <= {sreg[WORD_W-2:0], 1'b0};
        bit_cnt      <= bit_cnt + 1'b1;
        if (match) hits <= hits + 1'b1;
      end
      if (report) begin
        serial_bit   <= 1'b0;
        serial_valid <= 1'b0;
        done         <= 1'b1;
        done_id      <= cur_id;
        hit_count    <= hits;
`ifndef SEQ_SCHED_FIXED_PRIO_EN
        last_id      <= cur_id;
`endif
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Randomized self-checking bench for seq_detect_scheduler against a word-level model.
module tb_seq_detect_scheduler;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned WORD_W = 8;
  localparam int unsigned PAT_W  = 4;
  localparam logic [PAT_W-1:0] PATTERN = 4'b1010;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned CNT_W  = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req;
  logic [NREQ*WORD_W-1:0] word_in;
  logic [NREQ-1:0]        grant;
  logic                   busy, serial_bit, serial_valid, done;
  logic [ID_W-1:0]        done_id;
  logic [CNT_W-1:0]       hit_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_last;
  int hold_id, hold_cnt;

  seq_detect_scheduler #(
    .NREQ(NREQ), .WORD_W(WORD_W), .PAT_W(PAT_W), .PATTERN(PATTERN)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .word_in(word_in),
    .grant(grant), .busy(busy), .serial_bit(serial_bit),
    .serial_valid(serial_valid), .done(done), .done_id(done_id),
    .hit_count(hit_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count every PAT_W-bit window of the word that equals the pattern.
  function automatic int ref_hits(input logic [WORD_W-1:0] w);
    int n = 0;
    for (int k = 0; k <= int'(WORD_W - PAT_W); k++) begin
      logic [WORD_W-1:0] s;
      s = w >> (WORD_W - PAT_W - k);
      if (s[PAT_W-1:0] == PATTERN) n++;
    end
    return n;
  endfunction

  function automatic int ref_pick(input logic [NREQ-1:0] r);
`ifdef SEQ_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < int'(NREQ); i++) if (r[i]) return i;
`else
    for (int i = 1; i <= int'(NREQ); i++) begin
      int idx;
      idx = (model_last + i) % NREQ;
      if (r[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  // Wait for one grant and follow that word through shift and report.
  task automatic serve(input bit rnd, output int gid, output int gcyc);
    int n;
    int exp_id;
    logic [WORD_W-1:0] w;
    gid = -1; gcyc = 0; n = 0;
    @(negedge clk);
    while (grant == '0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (grant == '0) begin
      check("grant_timeout", 32'd0, 32'd1);
      return;
    end
    exp_id = ref_pick(req);
    w = word_in[exp_id*WORD_W +: WORD_W];
    gid = exp_id; gcyc = cyc;
    check("grant", 32'(grant), 32'(1) << exp_id);
    check("busy_grant", 32'(busy), 32'd1);
    check("sv_grant", 32'(serial_valid), 32'd0);
    model_last = exp_id;
    if (rnd) begin
      if ($urandom_range(0, 1) == 1) req[exp_id] = 1'b0;
      req = req | (NREQ'($urandom) & NREQ'($urandom));
      if (req == '0) req[$urandom_range(0, NREQ-1)] = 1'b1;
      word_in = $urandom;
    end
    for (int k = 1; k <= int'(WORD_W); k++) begin
      @(negedge clk);
      check("serial_valid", 32'(serial_valid), 32'd1);
      check("serial_bit", 32'(serial_bit), 32'(w[WORD_W-k]));
      check("busy_shift", 32'(busy), 32'd1);
      check("grant_shift", 32'(grant), 32'd0);
      check("done_shift", 32'(done), 32'd0);
    end
    @(negedge clk);
    hold_id = exp_id;
    hold_cnt = ref_hits(w);
    check("done", 32'(done), 32'd1);
    check("done_id", 32'(done_id), 32'(hold_id));
    check("hit_count", 32'(hit_count), 32'(hold_cnt));
    check("busy_report", 32'(busy), 32'd1);
    check("sv_report", 32'(serial_valid), 32'd0);
    check("grant_report", 32'(grant), 32'd0);
  endtask

  task automatic set_word(input int id, input logic [WORD_W-1:0] w);
    word_in[id*WORD_W +: WORD_W] = w;
  endtask

  initial begin
    int gid, gcyc, pcyc, bad;
    reset = 1'b0; req = '0; word_in = '0;
    model_last = NREQ - 1;
    hold_id = 0; hold_cnt = 0;
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sv", 32'(serial_valid | serial_bit), 32'd0);
    check("rst_id_cnt", 32'({done_id, hit_count}), 32'd0);
    reset = 1'b1;

    // Single requester, alternating word.
    req = 4'b0001; set_word(0, 8'hAA);
    serve(1'b0, gid, gcyc);
    req = 4'b0010; set_word(1, 8'hFF);
    serve(1'b0, gid, gcyc);
    set_word(1, 8'h0A);
    serve(1'b0, gid, gcyc);
    set_word(1, 8'hA5);
    serve(1'b0, gid, gcyc);
    set_word(1, 8'h50);
    serve(1'b0, gid, gcyc);
    req = '0;

    // Idle: no grants, results held.
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (grant != '0 || busy || done || int'(done_id) != hold_id || int'(hit_count) != hold_cnt) bad++;
    end
    check("idle_hold", 32'(bad), 32'd0);

    // All requesting: arbitration order and back-to-back spacing.
    req = 4'b1111; word_in = $urandom;
    serve(1'b0, gid, pcyc);
    repeat (4) begin
      serve(1'b0, gid, gcyc);
      check("gap", 32'(gcyc - pcyc), 32'(WORD_W + 2));
      pcyc = gcyc;
    end

    // Requesters 1 and 3, then only 3.
    req = 4'b1010;
    repeat (3) serve(1'b0, gid, gcyc);
    req = 4'b1000;
    serve(1'b0, gid, gcyc);
    check("req3_served", 32'(gid), 32'd3);
    req = '0;

    // Reset in the middle of SHIFT.
    repeat (2) @(negedge clk);
    req = 4'b0001; set_word(0, 8'hAA);
    @(negedge clk);
    while (grant == '0 && cyc < 5000) @(negedge clk);
    check("rst_mid_grant", 32'(grant), 32'd1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_out", 32'({grant, busy, serial_bit, serial_valid, done}), 32'd0);
    check("rst_mid_res", 32'({done_id, hit_count}), 32'd0);
    model_last = NREQ - 1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    check("rst_mid_nodone", 32'(bad), 32'd0);
    reset = 1'b1;
    serve(1'b0, gid, gcyc);
    check("rst_fresh_id", 32'(gid), 32'd0);

    // Randomized traffic.
    req = NREQ'($urandom) | 4'b0001; word_in = $urandom;
    repeat (40) serve(1'b1, gid, gcyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
